branch_predictor_bimodal: RTL and testbench

- Parametrised successor to the single-entry 2-bit predictor.
- PC-indexed table of 2^INDEX_BITS saturating counters, each CTR_BITS wide.
- Fetch gets a combinational prediction. EX writes the resolved outcome back one clock later, synchronously.
- Tracks resolved-branch and mispredict counts for performance monitoring. Sits beside IF (lookup) and EX (update) in the pipelined core.

---
 rtl/branch_predictor_bimodal.sv | 91 +++++++++
 tb/tb_branch_predictor_bimodal.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor_bimodal.sv
// Bimodal branch predictor: PC-indexed table of saturating counters plus resolve/mispredict counters.
// Define BRANCH_PREDICTOR_GSHARE_EN to XOR a committed global history register into the fetch index.
module branch_predictor_bimodal #(
    parameter int INDEX_BITS = 4,
    parameter int CTR_BITS   = 2,
    parameter int PC_LSB     = 2,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           if_pc,
    output logic                  prediction,
    output logic [INDEX_BITS-1:0] if_index,
    input  logic                  branchex,
    input  logic [INDEX_BITS-1:0] ex_index,
    input  logic                  ex_pred,
    input  logic                  outcome,
    output logic                  mispredict,
    output logic [CNT_W-1:0]      branch_count,
    output logic [CNT_W-1:0]      mispredict_count
);
    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

    function automatic logic [CTR_BITS-1:0] ctr_next(input logic [CTR_BITS-1:0] c,
                                                     input logic taken);
        if (taken)
            return (&c) ? c : c + CTR_BITS'(1);
        else
            return (c == '0) ? c : c - CTR_BITS'(1);
    endfunction

    function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [CTR_BITS-1:0]   ctr_tbl [ENTRIES];
    logic [INDEX_BITS-1:0] pc_field;
    logic                  mispredict_p1;
    logic                  unused_pc;

    assign pc_field  = if_pc[PC_LSB +: INDEX_BITS];
    // Only the index field matters; the remaining PC bits alias by design.
    assign unused_pc = ^if_pc;

`ifdef BRANCH_PREDICTOR_GSHARE_EN
    logic [INDEX_BITS-1:0] ghr;

    always_ff @(posedge clk) begin
        if (!rst_n)
            ghr <= '0;
        else if (branchex)
            ghr <= {ghr[INDEX_BITS-2:0], outcome};
    end

    assign if_index = pc_field ^ ghr;
`else
    assign if_index = pc_field;
`endif

    // IF lookup: combinational read, no bypass from a same-cycle EX write
    assign prediction = ctr_tbl[if_index][CTR_BITS-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++)
                ctr_tbl[i] <= CTR_INIT;
        end else if (branchex) begin
            ctr_tbl[ex_index] <= ctr_next(ctr_tbl[ex_index], outcome);
        end
    end

    // EX resolution -> stage p1: mispredict flag and performance counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mispredict_p1    <= 1'b0;
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            mispredict_p1 <= branchex & (ex_pred ^ outcome);
            if (branchex) begin
                branch_count <= cnt_sat_inc(branch_count);
                if (ex_pred ^ outcome)
                    mispredict_count <= cnt_sat_inc(mispredict_count);
            end
        end
    end

    assign mispredict = mispredict_p1;

endmodule

// File: tb/tb_branch_predictor_bimodal.sv
// Scoreboard bench for branch_predictor_bimodal (CNT_W = 4 so counter saturation is reachable).
module tb_branch_predictor_bimodal;
    localparam int CNT_W = 4;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [31:0]      if_pc = '0;
    logic             prediction;
    logic [3:0]       if_index;
    logic             branchex = 1'b0;
    logic [3:0]       ex_index = '0;
    logic             ex_pred = 1'b0;
    logic             outcome = 1'b0;
    logic             mispredict;
    logic [CNT_W-1:0] branch_count;
    logic [CNT_W-1:0] mispredict_count;

    exp_t        sb[$];
    logic [31:0] obs[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [3:0]  mdl_ghr = '0;

    branch_predictor_bimodal #(
        .INDEX_BITS(4), .CTR_BITS(2), .PC_LSB(2), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .prediction(prediction),
        .if_index(if_index), .branchex(branchex), .ex_index(ex_index),
        .ex_pred(ex_pred), .outcome(outcome), .mispredict(mispredict),
        .branch_count(branch_count), .mispredict_count(mispredict_count)
    );

    always #5 clk = ~clk;

    // PC whose fetch index lands on idx given the history the bench expects
    function automatic logic [31:0] pc_for(input logic [3:0] idx, input logic [31:0] hi);
        return hi | ({28'b0, idx ^ mdl_ghr} << 2);
    endfunction

    task automatic note_ghr(input logic o);
`ifdef BRANCH_PREDICTOR_GSHARE_EN
        mdl_ghr = {mdl_ghr[2:0], o};
`else
        mdl_ghr = (o === 1'bx) ? 4'hx : 4'h0;
`endif
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        branchex = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        mdl_ghr = '0;
    endtask

    task automatic upd(input logic [3:0] idx, input logic p, input logic o);
        branchex = 1'b1;
        ex_index = idx;
        ex_pred = p;
        outcome = o;
        @(posedge clk);
        #1;
        branchex = 1'b0;
        note_ghr(o);
    endtask

    task automatic look(input logic [31:0] pc);
        if_pc = pc;
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        logic [31:0] o;
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            look(pc_for(4'(i), 32'h0));
            sb.push_back('{$sformatf("rst_pred[%0d]", i), 32'd0});
            obs.push_back(32'(prediction));
            sb.push_back('{$sformatf("rst_index[%0d]", i), 32'(i)});
            obs.push_back(32'(if_index));
        end
        sb.push_back('{"rst_branch_count", 32'd0});     obs.push_back(32'(branch_count));
        sb.push_back('{"rst_mispredict_count", 32'd0}); obs.push_back(32'(mispredict_count));
        sb.push_back('{"rst_mispredict", 32'd0});       obs.push_back(32'(mispredict));
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = obs.pop_front(); vectors++;
            if (o !== e.val) begin
                miscompares++;
                $display("FAIL %s: got %0h, expected %0h", e.tag, o, e.val);
            end
        end
    endtask

    task automatic test_saturate_up();
        exp_t e;
        logic [31:0] o;
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            upd(4'd4, 1'b0, 1'b1);
            sb.push_back('{$sformatf("up_mispredict[%0d]", k), 32'd1}); obs.push_back(32'(mispredict));
            look(pc_for(4'd4, 32'h0));
            sb.push_back('{$sformatf("up_pred[%0d]", k), 32'd1});       obs.push_back(32'(prediction));
        end
        sb.push_back('{"up_branch_count", 32'd3});     obs.push_back(32'(branch_count));
        sb.push_back('{"up_mispredict_count", 32'd3}); obs.push_back(32'(mispredict_count));
        upd(4'd4, 1'b1, 1'b0);
        look(pc_for(4'd4, 32'h0));
        sb.push_back('{"down_pred_10", 32'd1}); obs.push_back(32'(prediction));
        upd(4'd4, 1'b1, 1'b0);
        look(pc_for(4'd4, 32'h0));
        sb.push_back('{"down_pred_01", 32'd0}); obs.push_back(32'(prediction));
        sb.push_back('{"down_branch_count", 32'd5});     obs.push_back(32'(branch_count));
        sb.push_back('{"down_mispredict_count", 32'd5}); obs.push_back(32'(mispredict_count));
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = obs.pop_front(); vectors++;
            if (o !== e.val) begin
                miscompares++;
                $display("FAIL %s: got %0h, expected %0h", e.tag, o, e.val);
            end
        end
    endtask

    task automatic test_aliasing();
        exp_t e;
        logic [31:0] o;
        apply_reset();
        upd(4'd4, 1'b0, 1'b1);
        upd(4'd4, 1'b0, 1'b1);
        look(pc_for(4'd4, 32'h0000_0040));
        sb.push_back('{"alias_pred", 32'd1});  obs.push_back(32'(prediction));
        sb.push_back('{"alias_index", 32'd4}); obs.push_back(32'(if_index));
        look(pc_for(4'd4, 32'hABCD_0000));
        sb.push_back('{"alias_hi_pred", 32'd1}); obs.push_back(32'(prediction));
        look(pc_for(4'd5, 32'h0));
        sb.push_back('{"isolate_pred", 32'd0});  obs.push_back(32'(prediction));
        sb.push_back('{"isolate_index", 32'd5}); obs.push_back(32'(if_index));
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = obs.pop_front(); vectors++;
            if (o !== e.val) begin
                miscompares++;
                $display("FAIL %s: got %0h, expected %0h", e.tag, o, e.val);
            end
        end
    endtask

    task automatic test_read_during_write();
        exp_t e;
        logic [31:0] o;
        apply_reset();
        if_pc = pc_for(4'd7, 32'h0);
        branchex = 1'b1;
        ex_index = 4'd7;
        ex_pred = 1'b0;
        outcome = 1'b1;
        #1;
        sb.push_back('{"rdw_index", 32'd7});     obs.push_back(32'(if_index));
        sb.push_back('{"rdw_same_cycle", 32'd0}); obs.push_back(32'(prediction));
        @(posedge clk);
        #1;
        branchex = 1'b0;
        note_ghr(1'b1);
        look(pc_for(4'd7, 32'h0));
        sb.push_back('{"rdw_next_cycle", 32'd1}); obs.push_back(32'(prediction));
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = obs.pop_front(); vectors++;
            if (o !== e.val) begin
                miscompares++;
                $display("FAIL %s: got %0h, expected %0h", e.tag, o, e.val);
            end
        end
    endtask

    task automatic test_mispredict_and_reset();
        exp_t e;
        logic [31:0] o;
        apply_reset();
        upd(4'd2, 1'b1, 1'b0);
        sb.push_back('{"mp_pulse", 32'd1}); obs.push_back(32'(mispredict));
        @(posedge clk);
        #1;
        sb.push_back('{"mp_pulse_end", 32'd0}); obs.push_back(32'(mispredict));
        upd(4'd2, 1'b0, 1'b0);
        sb.push_back('{"mp_correct", 32'd0}); obs.push_back(32'(mispredict));
        upd(4'd9, 1'b0, 1'b1);
        sb.push_back('{"pre_rst_branch_count", 32'd3});     obs.push_back(32'(branch_count));
        sb.push_back('{"pre_rst_mispredict_count", 32'd2}); obs.push_back(32'(mispredict_count));
        branchex = 1'b1;
        ex_index = 4'd9;
        ex_pred = 1'b0;
        outcome = 1'b1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        branchex = 1'b0;
        mdl_ghr = '0;
        sb.push_back('{"rstwin_branch_count", 32'd0});     obs.push_back(32'(branch_count));
        sb.push_back('{"rstwin_mispredict_count", 32'd0}); obs.push_back(32'(mispredict_count));
        sb.push_back('{"rstwin_mispredict", 32'd0});       obs.push_back(32'(mispredict));
        look(pc_for(4'd9, 32'h0));
        sb.push_back('{"rstwin_pred", 32'd0}); obs.push_back(32'(prediction));
        upd(4'd9, 1'b0, 1'b1);
        look(pc_for(4'd9, 32'h0));
        sb.push_back('{"rstwin_weak_nt", 32'd1}); obs.push_back(32'(prediction));
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = obs.pop_front(); vectors++;
            if (o !== e.val) begin
                miscompares++;
                $display("FAIL %s: got %0h, expected %0h", e.tag, o, e.val);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [31:0] o;
        apply_reset();
        branchex = 1'b1;
        ex_index = 4'd3;
        ex_pred = 1'b0;
        outcome = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            note_ghr(1'b1);
            sb.push_back('{$sformatf("b2b_mispredict[%0d]", k), 32'd1}); obs.push_back(32'(mispredict));
            sb.push_back('{$sformatf("b2b_count[%0d]", k), 32'(k + 1)}); obs.push_back(32'(branch_count));
        end
        branchex = 1'b0;
        look(pc_for(4'd3, 32'h0));
        sb.push_back('{"b2b_pred", 32'd1}); obs.push_back(32'(prediction));
        @(posedge clk);
        #1;
        sb.push_back('{"b2b_idle_mispredict", 32'd0}); obs.push_back(32'(mispredict));
        sb.push_back('{"b2b_idle_count", 32'd3});      obs.push_back(32'(branch_count));
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = obs.pop_front(); vectors++;
            if (o !== e.val) begin
                miscompares++;
                $display("FAIL %s: got %0h, expected %0h", e.tag, o, e.val);
            end
        end
    endtask

    task automatic test_count_saturation();
        exp_t e;
        logic [31:0] o;
        apply_reset();
        for (int k = 1; k <= 20; k++) begin
            upd(4'd0, 1'b0, 1'b1);
            if (k == 14 || k == 15 || k == 20) begin
                sb.push_back('{$sformatf("sat_branch_count[%0d]", k), 32'(k > 15 ? 15 : k)});
                obs.push_back(32'(branch_count));
                sb.push_back('{$sformatf("sat_mispredict_count[%0d]", k), 32'(k > 15 ? 15 : k)});
                obs.push_back(32'(mispredict_count));
            end
        end
        look(pc_for(4'd0, 32'h0));
        sb.push_back('{"sat_pred", 32'd1}); obs.push_back(32'(prediction));
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = obs.pop_front(); vectors++;
            if (o !== e.val) begin
                miscompares++;
                $display("FAIL %s: got %0h, expected %0h", e.tag, o, e.val);
            end
        end
    endtask

`ifdef BRANCH_PREDICTOR_GSHARE_EN
    task automatic test_gshare();
        exp_t e;
        logic [31:0] o;
        apply_reset();
        upd(4'd0, 1'b0, 1'b1);
        upd(4'd0, 1'b0, 1'b1);
        upd(4'd0, 1'b0, 1'b0);
        upd(4'd0, 1'b0, 1'b1);
        look(32'h0000_0000);
        sb.push_back('{"gshare_index_pc0", 32'd13}); obs.push_back(32'(if_index));
        look(32'h0000_0034);
        sb.push_back('{"gshare_index_pc34", 32'd0}); obs.push_back(32'(if_index));
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = obs.pop_front(); vectors++;
            if (o !== e.val) begin
                miscompares++;
                $display("FAIL %s: got %0h, expected %0h", e.tag, o, e.val);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_saturate_up();
        test_aliasing();
        test_read_during_write();
        test_mispredict_and_reset();
        test_back_to_back();
        test_count_saturation();
`ifdef BRANCH_PREDICTOR_GSHARE_EN
        test_gshare();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
